// File: rtl/core_run_ctrl.sv
// Run sequencer for the 9-bit-ISA core: launches/frees the core, watchdogs the run and muxes dat_mem.
// Optional single-step control (step_mode/step inputs) is compiled in with `define SINGLE_STEP_EN.
module core_run_ctrl #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int MAX_CYC = 4000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
`ifdef SINGLE_STEP_EN
    input  logic          i_step_mode,
    input  logic          i_step,
`endif
    input  logic          i_core_done,
    output logic          o_core_rst,
    output logic          o_core_en,
    input  logic [AW-1:0] i_core_addr,
    input  logic [DW-1:0] i_core_wdata,
    input  logic          i_core_we,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_we,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_timeout,
    output logic [CW-1:0] o_cyc_cnt
);

    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_RUN      = 3'd2,
        ST_DONE     = 3'd3,
        ST_TIMEOUT  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [RCW-1:0]   r_rst_cnt;
    logic [CW-1:0]    r_cyc_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic             r_core_rst;
    logic             r_core_en;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic             r_host_ack;
    logic [DW-1:0]    r_host_rdata;
    logic             w_core_rst_nxt;
    logic             w_core_en_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_timeout_nxt;
    logic             w_host_side;
    logic             w_host_acc;
    logic             w_launch;
    logic             w_tick;
    logic             w_step_gate;

`ifdef SINGLE_STEP_EN
    assign w_step_gate = ~i_step_mode | i_step;
`else
    assign w_step_gate = 1'b1;
`endif

    // core_en is registered, so in RUN it marks exactly the cycles the core advances
    assign w_tick      = r_core_en;
    assign w_cnt_inc   = r_cyc_cnt + {{(CW-1){1'b0}}, 1'b1};
    assign w_host_side = (r_state != ST_RUN) && (r_state != ST_CORE_RST);
    assign w_host_acc  = w_host_side & i_host_req & ~r_host_ack;
    // a pending or just-acked host transaction always wins over a launch request
    assign w_launch    = i_start & ~i_host_req & ~r_host_ack;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: abort > done > watchdog while running
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (w_launch) begin
                    w_state_nxt = ST_CORE_RST;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_CORE_RST: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_rst_cnt == RCW'(RST_CYC - 1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_CORE_RST;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick && i_core_done && (r_cyc_cnt != {CW{1'b0}})) begin
                    w_state_nxt = ST_DONE;
                end else if (w_tick && (w_cnt_inc == CW'(MAX_CYC - 1))) begin
                    w_state_nxt = ST_TIMEOUT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state, registered below
    always_comb begin
        w_core_rst_nxt = 1'b0;
        w_core_en_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_timeout_nxt  = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_core_rst_nxt = 1'b1;
            end
            ST_CORE_RST: begin
                w_core_rst_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
            ST_RUN: begin
                w_core_en_nxt  = w_step_gate;
                w_busy_nxt     = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt     = 1'b1;
            end
            ST_TIMEOUT: begin
                w_timeout_nxt  = 1'b1;
            end
            default: begin
                w_core_rst_nxt = 1'b1;
            end
        endcase
    end

    // Counters, registered status outputs and host handshake
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rst_cnt    <= {RCW{1'b0}};
            r_cyc_cnt    <= {CW{1'b0}};
            r_core_rst   <= 1'b1;
            r_core_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= {DW{1'b0}};
        end else begin
            if (r_state == ST_CORE_RST) begin
                r_rst_cnt <= r_rst_cnt + {{(RCW-1){1'b0}}, 1'b1};
            end else begin
                r_rst_cnt <= {RCW{1'b0}};
            end
            if ((w_state_nxt == ST_CORE_RST) && (r_state != ST_CORE_RST)) begin
                r_cyc_cnt <= {CW{1'b0}};
            end else if ((r_state == ST_RUN) && w_tick) begin
                r_cyc_cnt <= w_cnt_inc;
            end else begin
                r_cyc_cnt <= r_cyc_cnt;
            end
            r_core_rst <= w_core_rst_nxt;
            r_core_en  <= w_core_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_timeout  <= w_timeout_nxt;
            r_host_ack <= w_host_acc;
            if (w_host_acc && !i_host_we) begin
                r_host_rdata <= i_mem_rdata;
            end else begin
                r_host_rdata <= r_host_rdata;
            end
        end
    end

    // dat_mem port mux: the core owns it in RUN, the host otherwise (no writes during CORE_RST)
    always_comb begin
        if (r_state == ST_RUN) begin
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
            o_mem_we    = i_core_we;
        end else begin
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_wdata;
            o_mem_we    = w_host_side & i_host_req & i_host_we & ~r_host_ack;
        end
    end

    assign o_core_rst   = r_core_rst;
    assign o_core_en    = r_core_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;
    assign o_cyc_cnt    = r_cyc_cnt;
    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: directed sequence with randomized data and run lengths,
// expectations from a run-length model and a reference copy of memory kept here.
module tb_core_run_ctrl;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int CW      = 16;
    localparam int RST_CYC = 2;
    localparam int MAX_CYC = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic          core_we    = 1'b0;
    logic          host_req   = 1'b0;
    logic          host_we    = 1'b0;
    logic [AW-1:0] core_addr  = '0;
    logic [AW-1:0] host_addr  = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [DW-1:0] host_wdata = '0;
`ifdef SINGLE_STEP_EN
    logic          step_mode  = 1'b0;
    logic          step       = 1'b0;
`endif
    logic          core_done;
    logic          core_rst, core_en, host_ack, mem_we, busy, done, timeout;
    logic [DW-1:0] host_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] cyc_cnt;

    int checks = 0;
    int errors = 0;

    // memory behind the DUT, and the bench's own expectation of its contents
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [AW-1:0] last_core_addr = '0;
    bit            core_wrote = 1'b0;

    // core stand-in: counts enabled cycles since its reset, raises done from the done_at-th one on
    int unsigned en_seen = 0;
    int unsigned done_at = 0;
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
        if (core_rst) en_seen <= 0;
        else if (core_en) en_seen <= en_seen + 1;
    end
    assign mem_rdata = env_mem[mem_addr];
    assign core_done = (done_at != 0) && (en_seen + 1 >= done_at);

    core_run_ctrl #(.AW(AW), .DW(DW), .CW(CW), .RST_CYC(RST_CYC), .MAX_CYC(MAX_CYC)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_abort     (abort),
`ifdef SINGLE_STEP_EN
        .i_step_mode (step_mode),
        .i_step      (step),
`endif
        .i_core_done (core_done),
        .o_core_rst  (core_rst),
        .o_core_en   (core_en),
        .i_core_addr (core_addr),
        .i_core_wdata(core_wdata),
        .i_core_we   (core_we),
        .i_host_req  (host_req),
        .i_host_we   (host_we),
        .i_host_addr (host_addr),
        .i_host_wdata(host_wdata),
        .o_host_ack  (host_ack),
        .o_host_rdata(host_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_timeout   (timeout),
        .o_cyc_cnt   (cyc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_core_en"},  core_en, 0);
        chk({tag, "_ack"},      host_ack, 0);
        chk({tag, "_rdata"},    host_rdata, 0);
        chk({tag, "_cyc_cnt"},  cyc_cnt, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_done"},     done, 0);
        chk({tag, "_timeout"},  timeout, 0);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int we_cyc = 0;
        host_addr = a; host_wdata = d; host_we = 1'b1; host_req = 1'b1;
        #1;
        if (mem_we === 1'b1) we_cyc++;
        chk("wr_mux_addr", mem_addr, a);
        @(negedge clk);
        chk("wr_ack", host_ack, 1);
        #1;
        if (mem_we === 1'b1) we_cyc++;
        host_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        chk("wr_ack_pulse", host_ack, 0);
        if (mem_we === 1'b1) we_cyc++;
        chk("wr_we_cycles", we_cyc, 1);
        ref_mem[a] = d;
    endtask

    task automatic host_read(input logic [AW-1:0] a);
        host_addr = a; host_we = 1'b0; host_req = 1'b1;
        @(negedge clk);
        chk("rd_ack", host_ack, 1);
        chk("rd_data", host_rdata, ref_mem[a]);
        host_req = 1'b0;
        @(negedge clk);
        chk("rd_ack_pulse", host_ack, 0);
        chk("rd_hold", host_rdata, ref_mem[a]);
    endtask

    task automatic launch();
        int rc = 0;
        int guard = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("launch_cnt_clr", cyc_cnt, 0);
        chk("launch_busy", busy, 1);
        while (core_en !== 1'b1 && guard < 20) begin
            if (busy === 1'b1 && core_rst === 1'b1) rc++;
            guard++;
            @(negedge clk);
        end
        chk("run_entered", core_en, 1);
        chk("rst_hold_cycles", rc, RST_CYC);
    endtask

    // d: RUN cycle in which the core first reports done (0 = never)
    task automatic run_body(input int d, input int abort_at, input int req_at, input logic [AW-1:0] req_addr);
        int d_eff, n_exp;
        int bad_run = 0, bad_ack = 0, bad_mux = 0;
        bit ends_done, aborted;
        // done during the first RUN cycle is ignored; the held flag is then taken one cycle later
        d_eff     = (d == 0) ? MAX_CYC : ((d < 2) ? 2 : d);
        ends_done = (d_eff <= MAX_CYC - 1);
        n_exp     = ends_done ? d_eff : MAX_CYC - 1;
        aborted   = (abort_at != 0) && (abort_at <= n_exp);
        if (aborted) n_exp = abort_at;
        done_at = d;
        for (int k = 1; k <= n_exp; k++) begin
            if (core_en !== 1'b1 || busy !== 1'b1 || cyc_cnt !== CW'(k - 1)) bad_run++;
            if (host_ack !== 1'b0) bad_ack++;
            if (k == req_at) begin
                host_addr = req_addr; host_we = 1'b0; host_req = 1'b1;
            end
            abort      = (k == abort_at);
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = 8'h80 | AW'($urandom_range(0, 127));
            core_wdata = DW'($urandom);
            if (core_we) begin
                ref_mem[core_addr] = core_wdata;
                last_core_addr = core_addr;
                core_wrote = 1'b1;
            end
            #1;
            if (mem_we !== core_we || mem_addr !== core_addr || mem_wdata !== core_wdata) bad_mux++;
            @(negedge clk);
        end
        core_we = 1'b0; abort = 1'b0;
        chk("run_cycles", bad_run, 0);
        chk("run_no_ack", bad_ack, 0);
        chk("run_mux", bad_mux, 0);
        chk("end_busy", busy, 0);
        chk("end_done", done, !aborted && ends_done);
        chk("end_timeout", timeout, !aborted && !ends_done);
        chk("end_core_en", core_en, 0);
        chk("end_core_rst", core_rst, aborted);
        if (!aborted) chk("end_cyc_cnt", cyc_cnt, n_exp);
        if (req_at != 0) begin
            chk("stall_ack_at_exit", host_ack, 0);
            @(negedge clk);
            chk("stall_ack", host_ack, 1);
            chk("stall_rdata", host_rdata, ref_mem[req_addr]);
            host_req = 1'b0;
            @(negedge clk);
            chk("stall_ack_pulse", host_ack, 0);
        end else begin
            @(negedge clk);
            chk("frozen_en", core_en, 0);
            if (!aborted) chk("cnt_hold", cyc_cnt, n_exp);
        end
    endtask

    initial begin
        logic [AW-1:0] addrs [4];
        logic [AW-1:0] a;
        int d;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle");

        // host access from IDLE
        host_write(8'h10, 8'h5A);
        host_read(8'h10);
        for (int i = 0; i < 4; i++) begin
            addrs[i] = AW'($urandom_range(32, 127));
            host_write(addrs[i], DW'($urandom));
        end
        for (int i = 3; i >= 0; i--) host_read(addrs[i]);

        // start with a request, then start during the ack cycle: both dropped
        host_addr = 8'h10; host_we = 1'b0; host_req = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("start_vs_req_ack", host_ack, 1);
        chk("start_vs_req_busy", busy, 0);
        host_req = 1'b0;
        @(negedge clk);
        chk("start_in_ack_busy", busy, 0);
        start = 1'b0;
        @(negedge clk);
        chk("start_dropped_busy", busy, 0);

        // done at RUN cycle 37, then random lengths, then the first-cycle boundary
        launch();
        run_body(37, 0, 0, 8'h00);
        if (core_wrote) host_read(last_core_addr);
        for (int i = 0; i < 2; i++) begin
            d = $urandom_range(2, 120);
            launch();
            run_body(d, 0, 0, 8'h00);
        end
        launch();
        run_body(1, 0, 0, 8'h00);

        // watchdog, host access afterwards, then done exactly at the watchdog limit
        launch();
        run_body(0, 0, 0, 8'h00);
        host_read(8'h10);
        launch();
        run_body(MAX_CYC - 1, 0, 0, 8'h00);

        // host read stalled through RUN, core done 5 cycles after the request
        launch();
        run_body(20, 0, 15, 8'h10);

        // abort coinciding with done, then reset during CORE_RST
        launch();
        run_body(10, 10, 0, 8'h00);
        chk("abort_idle_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("relaunch_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_core_rst");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_core_rst", core_rst, 1);

        // reset coinciding with a host request: no ack
        a = 8'h22;
        host_addr = a; host_we = 1'b1; host_wdata = 8'hC3; host_req = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("rst_txn_ack", host_ack, 0);
        reset = 1'b0; host_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        chk("rst_txn_ack_after", host_ack, 0);

`ifdef SINGLE_STEP_EN
        begin
            int ec = 0;
            int guard = 0;
            done_at = 0;
            step_mode = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int p = 0; p < 3; p++) begin
                repeat ($urandom_range(RST_CYC + 1, RST_CYC + 4)) begin
                    if (core_en === 1'b1) ec++;
                    @(negedge clk);
                end
                step = 1'b1;
                if (core_en === 1'b1) ec++;
                @(negedge clk);
                step = 1'b0;
            end
            repeat (4) begin
                if (core_en === 1'b1) ec++;
                @(negedge clk);
            end
            chk("step_en_cycles", ec, 3);
            chk("step_cyc_cnt", cyc_cnt, 3);
            chk("step_busy", busy, 1);
            done_at = 6;
            step_mode = 1'b0;
            while (done !== 1'b1 && guard < 20) begin
                guard++;
                @(negedge clk);
            end
            chk("step_free_done", done, 1);
            chk("step_free_cnt", cyc_cnt, 6);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
